// File: rtl/key_onehot_debouncer.sv
// Key front end for the 8-to-3 encoder: synchronises raw key lines, picks the
// highest-priority key, debounces press and release, and holds a clean one-hot code.
module key_onehot_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] keys_in,
  output logic [7:0] onehot_out,
  output logic       key_valid,
  output logic       key_held,
  output logic [7:0] press_count
);

  localparam int unsigned KW = 8;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] sync1, keys_s;
  logic [KW-1:0] pri;
  logic [KW-1:0] cand, cand_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [KW-1:0] onehot_nxt;
  logic          valid_nxt;
  logic          held_nxt;
  logic [CW-1:0] count_nxt;

  // Highest set bit wins; later iterations overwrite lower bits.
  always_comb begin
    pri = '0;
    for (int unsigned i = 0; i < KW; i++) begin
      if (keys_s[i]) pri = KW'(1) << i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '0;
      keys_s      <= '0;
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      onehot_out  <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      press_count <= '0;
    end else begin
      sync1       <= keys_in;
      keys_s      <= sync1;
      state       <= state_nxt;
      cand        <= cand_nxt;
      cnt         <= cnt_nxt;
      onehot_out  <= onehot_nxt;
      key_valid   <= valid_nxt;
      key_held    <= held_nxt;
      press_count <= count_nxt;
    end
  end

  // cnt counts samples already seen, so the Nth matching sample is when cnt == N-1.
  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    cnt_nxt    = cnt;
    onehot_nxt = onehot_out;
    valid_nxt  = 1'b0;
    held_nxt   = key_held;
    count_nxt  = press_count;
    case (state)
      IDLE: begin
        if (pri != '0) begin
          cand_nxt = pri;
          if (DEBOUNCE_CYCLES == 1) begin
            onehot_nxt = pri;
            valid_nxt  = 1'b1;
            held_nxt   = 1'b1;
            count_nxt  = press_count + CW'(1);
            state_nxt  = HELD;
          end else begin
            cnt_nxt   = CW'(1);
            state_nxt = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (pri == cand) begin
          if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            onehot_nxt = cand;
            valid_nxt  = 1'b1;
            held_nxt   = 1'b1;
            count_nxt  = press_count + CW'(1);
            state_nxt  = HELD;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      HELD: begin
        if (keys_s == '0) begin
          if (DEBOUNCE_CYCLES == 1) begin
            onehot_nxt = '0;
            held_nxt   = 1'b0;
            state_nxt  = IDLE;
          end else begin
            cnt_nxt   = CW'(1);
            state_nxt = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (keys_s == '0) begin
          if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            onehot_nxt = '0;
            held_nxt   = 1'b0;
            state_nxt  = IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else begin
          state_nxt = HELD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_onehot_debouncer.sv
// Directed bench for key_onehot_debouncer: each press pushes its expected strobe
// cycle/code/count to a queue that a negedge monitor pops when key_valid fires.
module tb_key_onehot_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] keys_in;
  logic [7:0] onehot_out;
  logic       key_valid;
  logic       key_held;
  logic [7:0] press_count;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  oh;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned errs = 0;
  int unsigned valid_seen = 0;
  int unsigned pushes = 0;
  logic [7:0]  exp_count = 8'h00;
  logic        prev_valid = 1'b0;

  key_onehot_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .keys_in(keys_in), .onehot_out(onehot_out),
    .key_valid(key_valid), .key_held(key_held), .press_count(press_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check32(input string tag, input int unsigned obs, input int unsigned exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive a key code now; the strobe is expected after edge E+5, i.e. at cyc+6.
  task automatic press(input logic [7:0] v, input logic [7:0] oh);
    keys_in   = v;
    exp_count = exp_count + 8'd1;
    q.push_back('{cyc: cyc + 6, oh: oh, cnt: exp_count});
    pushes++;
  endtask

  task automatic check_idle(input string tag);
    check8({tag, "_onehot"}, onehot_out, 8'h00);
    check8({tag, "_held"}, {7'd0, key_held}, 8'h00);
    check8({tag, "_valid"}, {7'd0, key_valid}, 8'h00);
  endtask

  // Scoreboard and invariants, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    check8("onehot0", {7'd0, $onehot0(onehot_out)}, 8'h01);
    if (q.size() > 0 && cyc > q[0].cyc) begin
      check32("valid_missing", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (key_valid) begin
      valid_seen++;
      check8("valid_double", {7'd0, prev_valid}, 8'h00);
      if (q.size() == 0) begin
        check8("valid_unexpected", {7'd0, key_valid}, 8'h00);
      end else begin
        e = q.pop_front();
        check32("valid_cycle", cyc, e.cyc);
        check8("valid_onehot", onehot_out, e.oh);
        check8("valid_count", press_count, e.cnt);
      end
    end
    prev_valid = key_valid;
  end

  initial begin
    int unsigned n;
    int unsigned v0;
    rst = 1'b1;
    keys_in = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    keys_in = 8'h00;
    check_idle("reset");
    check8("reset_count", press_count, 8'h00);
    wait_cyc(cyc + 6);
    check_idle("post_reset");
    check8("post_reset_count", press_count, 8'h00);

    // Clean press of key 2, release timing
    n = cyc;
    press(8'h04, 8'h04);
    wait_cyc(n + 12);
    check8("k2_onehot", onehot_out, 8'h04);
    check8("k2_held", {7'd0, key_held}, 8'h01);
    check8("k2_count", press_count, 8'h01);
    keys_in = 8'h00;
    wait_cyc(n + 17);
    check8("k2_rel_early_onehot", onehot_out, 8'h04);
    check8("k2_rel_early_held", {7'd0, key_held}, 8'h01);
    wait_cyc(n + 18);
    check_idle("k2_released");
    wait_cyc(n + 21);

    // Bouncy key 4
    n = cyc;
    keys_in = 8'h10; wait_cyc(n + 2);
    keys_in = 8'h00; wait_cyc(n + 3);
    keys_in = 8'h10; wait_cyc(n + 4);
    keys_in = 8'h00; wait_cyc(n + 5);
    press(8'h10, 8'h10);
    wait_cyc(n + 15);
    check8("k4_onehot", onehot_out, 8'h10);
    check8("k4_count", press_count, 8'h02);
    keys_in = 8'h00;
    wait_cyc(n + 23);
    check_idle("k4_released");

    // Priority 0x81 -> 0x80, then ignored changes and a short release glitch
    n = cyc;
    press(8'h81, 8'h80);
    wait_cyc(n + 10);
    check8("k7_onehot", onehot_out, 8'h80);
    keys_in = 8'h0C;
    wait_cyc(n + 18);
    check8("k7_other_onehot", onehot_out, 8'h80);
    check8("k7_other_held", {7'd0, key_held}, 8'h01);
    keys_in = 8'h00;
    wait_cyc(n + 20);
    keys_in = 8'h81;
    wait_cyc(n + 28);
    check8("k7_glitch_onehot", onehot_out, 8'h80);
    check8("k7_glitch_held", {7'd0, key_held}, 8'h01);
    check8("k7_count", press_count, 8'h03);
    keys_in = 8'h00;
    wait_cyc(n + 36);
    check_idle("k7_released");

    // Reset mid-debounce of key 1
    n = cyc;
    keys_in = 8'h02;
    wait_cyc(n + 3);
    rst = 1'b1;
    wait_cyc(n + 4);
    rst = 1'b0;
    exp_count = 8'h00;
    check_idle("midrst");
    check8("midrst_count", press_count, 8'h00);
    exp_count = 8'h01;
    q.push_back('{cyc: n + 10, oh: 8'h02, cnt: 8'h01});
    pushes++;
    wait_cyc(n + 14);
    check8("k1_onehot", onehot_out, 8'h02);
    check8("k1_count", press_count, 8'h01);
    keys_in = 8'h00;
    wait_cyc(n + 22);
    check_idle("k1_released");

    // Clear the counter, then 256 presses of key 0 to wrap it
    rst = 1'b1;
    wait_cyc(cyc + 1);
    rst = 1'b0;
    exp_count = 8'h00;
    check8("wrap_start_count", press_count, 8'h00);
    v0 = valid_seen;
    for (int i = 0; i < 256; i++) begin
      n = cyc;
      press(8'h01, 8'h01);
      wait_cyc(n + 7);
      keys_in = 8'h00;
      wait_cyc(n + 14);
    end
    wait_cyc(cyc + 2);
    check32("wrap_pulses", valid_seen - v0, 256);
    check8("wrap_count", press_count, exp_count);
    check8("wrap_count_zero", press_count, 8'h00);
    check_idle("wrap_end");

    check32("queue_empty", q.size(), 0);
    check32("total_pulses", valid_seen, pushes);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
